// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared widths, NZCV bit positions and EXE/MEM payload type
package arm_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic                  wb_en;
        logic                  mem_r;
        logic                  mem_w;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     store_val;
    } exe_mem_payload_t;

    localparam int PAYLOAD_W = $bits(exe_mem_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with valid/ready and flush
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, drain;

    // in_ready comes straight from a flop so it never depends on out_ready
    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

    assign accept = in_valid_i & ~skid_valid_q & ~flush_i;
    assign drain  = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = in_data_i;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_data_i;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// rtl/exe_mem_stage_reg.sv - EXE/MEM pipeline register with NZCV status; EXE_MEM_FWD_EN adds forwarding taps
module exe_mem_stage_reg #(
    parameter int DATA_W     = arm_pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = arm_pipe_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic                  in_alu_carry,
    input  logic                  in_alu_ovf,
    input  logic                  in_arith,
    input  logic                  in_s_bit,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r,
    input  logic                  in_mem_w,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_store_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic                  out_wb_en,
    output logic                  out_mem_r,
    output logic                  out_mem_w,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]     out_store_val,
`ifdef EXE_MEM_FWD_EN
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [3:0]            status
);

    import arm_pipe_pkg::*;

    exe_mem_payload_t in_pl, out_pl;
    logic             accept;
    logic [3:0]       status_q, status_d;

    always_comb begin
        in_pl            = '0;
        in_pl.alu_result = in_alu_result;
        in_pl.wb_en      = in_wb_en;
        in_pl.mem_r      = in_mem_r;
        in_pl.mem_w      = in_mem_w;
        in_pl.dest       = in_dest;
        in_pl.store_val  = in_store_val;
    end

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_pl),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_pl)
    );

    assign out_alu_result = out_pl.alu_result;
    assign out_wb_en      = out_pl.wb_en;
    assign out_mem_r      = out_pl.mem_r;
    assign out_mem_w      = out_pl.mem_w;
    assign out_dest       = out_pl.dest;
    assign out_store_val  = out_pl.store_val;

    // Flags land at accept so a stalled entry never delays flag visibility
    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        status_d = status_q;
        if (accept && in_s_bit) begin
            status_d[FLAG_N] = in_alu_result[DATA_W-1];
            status_d[FLAG_Z] = (in_alu_result == '0);
            if (in_arith) begin
                status_d[FLAG_C] = in_alu_carry;
                status_d[FLAG_V] = in_alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= 4'b0000;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;

`ifdef EXE_MEM_FWD_EN
    assign fwd_valid = out_valid & out_wb_en & ~out_mem_r;
    assign fwd_dest  = out_dest;
    assign fwd_data  = out_alu_result;
`endif

endmodule
